benes_route_pipe: RTL and testbench

//  Pipelined Benes data network; consumes the control word produced by cbg_benes and routes SIZE lanes.

---
 rtl/benes_route_pipe_pkg.sv | 34 +++
 rtl/benes_route_pipe_column.sv | 43 ++++
 rtl/benes_route_pipe.sv | 110 +++++++++++
 tb/tb_benes_route_pipe.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/benes_route_pipe_pkg.sv
// Sizing helpers and wiring maps shared by the pipelined Benes router and its columns.
package benes_route_pipe_pkg;

    function automatic int tag_width(input int size);
        return $clog2(size);
    endfunction

    function automatic int stage_count(input int size);
        return 2 * $clog2(size) - 1;
    endfunction

    function automatic int ctrl_width(input int size);
        return stage_count(size) * (size >> 1);
    endfunction

    // Unshuffle inside blocks of blk wires: even local wires go to the upper half, odd to the lower.
    function automatic int unshuffle_idx(input int idx, input int blk);
        int k;
        k = idx % blk;
        return (idx - k) + (k % 2) * (blk / 2) + k / 2;
    endfunction

    // Offset of register r's ctrl field when the per-stage fields are packed back to back.
    // Register r keeps the bits of columns r+1..ncol-1, so its field shrinks by one column per stage.
    function automatic int ctrl_base(input int r, input int ncol, input int half);
        int acc;
        acc = 0;
        for (int q = 0; q < r; q++) begin
            acc += (ncol - 1 - q) * half;
        end
        return acc;
    endfunction

endpackage

// File: rtl/benes_route_pipe_column.sv
// One Benes switch column with its surrounding wiring; purely combinational.
module benes_column
    import benes_route_pipe_pkg::*;
#(
    parameter int SIZE   = 32,
    parameter int DWIDTH = 16,
    parameter int COL    = 0
) (
    input  logic [SIZE-1:0][DWIDTH-1:0] lanes,
    input  logic [SIZE/2-1:0]           sw,
    output logic [SIZE-1:0][DWIDTH-1:0] routed
);
    localparam int TW   = tag_width(SIZE);
    localparam int NCOL = stage_count(SIZE);
    // Second-half columns undo the unshuffle of their mirror column before switching.
    localparam int PRE_BLK  = (COL > TW - 1) ? (SIZE >> (NCOL - 1 - COL)) : SIZE;
    localparam int POST_BLK = (COL < TW - 1) ? (SIZE >> COL) : SIZE;

    logic [SIZE-1:0][DWIDTH-1:0] pre_w;
    logic [SIZE-1:0][DWIDTH-1:0] sw_w;

    if (COL > TW - 1) begin : g_pre
        for (genvar k = 0; k < SIZE; k++) begin : g_lane
            assign pre_w[k] = lanes[unshuffle_idx(k, PRE_BLK)];
        end
    end else begin : g_nopre
        assign pre_w = lanes;
    end

    for (genvar j = 0; j < SIZE / 2; j++) begin : g_sw
        assign sw_w[2*j]   = sw[j] ? pre_w[2*j+1] : pre_w[2*j];
        assign sw_w[2*j+1] = sw[j] ? pre_w[2*j]   : pre_w[2*j+1];
    end

    if (COL < TW - 1) begin : g_post
        for (genvar k = 0; k < SIZE; k++) begin : g_lane
            assign routed[unshuffle_idx(k, POST_BLK)] = sw_w[k];
        end
    end else begin : g_nopost
        assign routed = sw_w;
    end

endmodule

// File: rtl/benes_route_pipe.sv
// Pipelined Benes data network: one switch column per register stage, ctrl travels with its beat.
module benes_route_pipe
    import benes_route_pipe_pkg::*;
#(
    parameter int  SIZE     = 32,
    parameter int  DWIDTH   = 16,
    localparam int TAGWIDTH = tag_width(SIZE),
    localparam int STAGES   = 2 * TAGWIDTH - 1,
    localparam int BITWIDTH = ctrl_width(SIZE)
) (
    input  logic                        clk,
    input  logic                        n_rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [SIZE-1:0][DWIDTH-1:0] in_data,
    input  logic [BITWIDTH-1:0]         in_ctrl,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [SIZE-1:0][DWIDTH-1:0] out_data
);
    localparam int HALF      = SIZE / 2;
    localparam int CTRL_BITS = ctrl_base(STAGES - 1, STAGES, HALF);

    typedef logic [SIZE-1:0][DWIDTH-1:0] beat_t;

    logic [STAGES-1:0]    valid_q;
    logic [STAGES-1:0]    up_valid;
    logic [STAGES-1:0]    rdy;
    logic                 chain_open;
    beat_t                data_q  [STAGES];
    beat_t                col_out [STAGES];
    logic [HALF-1:0]      col_sw  [STAGES];
    logic [CTRL_BITS-1:0] ctrl_q;

    assign up_valid = {valid_q[STAGES-2:0], in_valid};

    // A stage can load if it is empty or everything below it will move this cycle.
    always_comb begin
        rdy        = '0;
        chain_open = out_ready;
        for (int r = STAGES - 1; r >= 0; r--) begin
            chain_open = chain_open | ~valid_q[r];
            rdy[r]     = chain_open;
        end
    end

    for (genvar c = 0; c < STAGES; c++) begin : g_col
        beat_t col_in;
        if (c == 0) begin : g_head
            assign col_in    = in_data;
            assign col_sw[c] = in_ctrl[HALF-1:0];
        end else begin : g_body
            assign col_in    = data_q[c-1];
            assign col_sw[c] = ctrl_q[ctrl_base(c - 1, STAGES, HALF) +: HALF];
        end
        benes_column #(
            .SIZE   (SIZE),
            .DWIDTH (DWIDTH),
            .COL    (c)
        ) u_col (
            .lanes  (col_in),
            .sw     (col_sw[c]),
            .routed (col_out[c])
        );
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            valid_q <= '0;
            for (int r = 0; r < STAGES; r++) begin
                data_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < STAGES; r++) begin
                if (rdy[r]) begin
                    valid_q[r] <= up_valid[r];
                    if (up_valid[r]) begin
                        data_q[r] <= col_out[r];
                    end
                end
            end
        end
    end

    // Each stage forwards only the column settings still ahead of the beat.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ctrl_q <= '0;
        end else begin
            for (int r = 0; r < STAGES - 1; r++) begin
                if (rdy[r] && up_valid[r]) begin
                    for (int c = r + 1; c < STAGES; c++) begin
                        if (r == 0) begin
                            ctrl_q[ctrl_base(r, STAGES, HALF) + (c - r - 1) * HALF +: HALF]
                                <= in_ctrl[c * HALF +: HALF];
                        end else begin
                            ctrl_q[ctrl_base(r, STAGES, HALF) + (c - r - 1) * HALF +: HALF]
                                <= ctrl_q[ctrl_base(r - 1, STAGES, HALF) + (c - r) * HALF +: HALF];
                        end
                    end
                end
            end
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = valid_q[STAGES-1];
    assign out_data  = data_q[STAGES-1];

endmodule

// File: tb/tb_benes_route_pipe.sv
// Scoreboard bench for benes_route_pipe: a 4-lane instance for directed cases, a 32-lane one for routed traffic.
module tb_benes_route_pipe;

    localparam int N  = 32;
    localparam int DW = 16;
    localparam int TW = 5;
    localparam int NC = 2 * TW - 1;
    localparam int H  = N / 2;
    localparam int BW = NC * H;
    localparam int VW = N * DW;

    typedef logic [N-1:0][DW-1:0] beat_t;
    typedef logic [3:0][DW-1:0]   beat4_t;

    logic clk   = 1'b0;
    logic n_rst = 1'b1;
    always #5 clk = ~clk;

    logic          in_valid32, in_ready32, out_valid32, out_ready32;
    beat_t         in_data32, out_data32;
    logic [BW-1:0] in_ctrl32;
    logic          in_valid4, in_ready4, out_valid4, out_ready4;
    beat4_t        in_data4, out_data4;
    logic [5:0]    in_ctrl4;

    benes_route_pipe #(.SIZE(N), .DWIDTH(DW)) dut32 (
        .clk       (clk),
        .n_rst     (n_rst),
        .in_valid  (in_valid32),
        .in_ready  (in_ready32),
        .in_data   (in_data32),
        .in_ctrl   (in_ctrl32),
        .out_valid (out_valid32),
        .out_ready (out_ready32),
        .out_data  (out_data32)
    );

    benes_route_pipe #(.SIZE(4), .DWIDTH(DW)) dut4 (
        .clk       (clk),
        .n_rst     (n_rst),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .in_data   (in_data4),
        .in_ctrl   (in_ctrl4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .out_data  (out_data4)
    );

    int n_cmp  = 0;
    int n_bad  = 0;
    int stalls = 0;
    int cyc    = 0;
    logic [VW-1:0] exp_q[$];
    int out_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, expv);
        end
    endtask

    always @(negedge clk) begin
        if (n_rst && out_valid32 && out_ready32) begin
            check_val("sb_has_entry", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) check_val("beat_data", out_data32, exp_q.pop_front());
            out_cyc.push_back(cyc);
        end
    end

    // Looping-algorithm router: inputs of a switch pair take different subnets, and so do outputs.
    function automatic logic [BW-1:0] route_ctrl(input int perm[N]);
        logic [BW-1:0] ctrl;
        int cur[N];
        int nxt[N];
        int inv[N];
        int sub[N];
        ctrl = '0;
        cur  = perm;
        nxt  = perm;
        for (int s = 0; s < TW; s++) begin
            int blk;
            blk = N >> s;
            for (int base = 0; base < N; base += blk) begin
                if (blk == 2) begin
                    ctrl[s*H + base/2] = (cur[base] == 1);
                end else begin
                    for (int k = 0; k < blk; k++) begin
                        inv[cur[base+k]] = k;
                        sub[k] = -1;
                    end
                    for (int j = 0; j < blk / 2; j++) begin
                        if (sub[2*j] < 0) begin
                            int i;
                            i = 2 * j;
                            sub[i] = 0;
                            for (int g = 0; g < blk; g++) begin
                                int i2;
                                i2 = inv[cur[base+i] ^ 1];
                                sub[i2] = 1 - sub[i];
                                if (sub[i2 ^ 1] >= 0) break;
                                sub[i2 ^ 1] = sub[i];
                                i = i2 ^ 1;
                            end
                        end
                    end
                    for (int k = 0; k < blk; k++) begin
                        int o;
                        o = cur[base+k];
                        if (k % 2 == 0) ctrl[s*H + base/2 + k/2] = (sub[k] == 1);
                        if (sub[k] == 0) ctrl[(NC-1-s)*H + base/2 + o/2] = o[0];
                        nxt[base + sub[k]*(blk/2) + k/2] = o / 2;
                    end
                end
            end
            cur = nxt;
        end
        return ctrl;
    endfunction

    task automatic rand_beat(output logic [BW-1:0] ctrl, output beat_t d, output beat_t e);
        int p[N];
        for (int i = 0; i < N; i++) p[i] = i;
        for (int i = N - 1; i > 0; i--) begin
            int j, t;
            j = $urandom_range(i, 0);
            t = p[i]; p[i] = p[j]; p[j] = t;
        end
        e = '0;
        for (int i = 0; i < N; i++) d[i] = DW'($urandom);
        for (int i = 0; i < N; i++) e[p[i]] = d[i];
        ctrl = route_ctrl(p);
    endtask

    // Holds the beat on the inputs until accepted; leaves in_valid high for back-to-back use.
    task automatic send32(input logic [BW-1:0] ctrl, input beat_t d, input beat_t e);
        in_ctrl32  = ctrl;
        in_data32  = d;
        in_valid32 = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready32) begin
                exp_q.push_back(e);
                @(posedge clk);
                #1;
                return;
            end
            stalls++;
        end
        check_val("send_timeout", in_ready32, 1);
    endtask

    task automatic drain(input string tag, input int budget);
        for (int t = 0; t < budget; t++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        check_val(tag, exp_q.size(), 0);
    endtask

    task automatic run4(input string tag, input logic [5:0] ctrl, input beat4_t expd);
        beat4_t din;
        din[0] = 16'hA000; din[1] = 16'hA001; din[2] = 16'hA002; din[3] = 16'hA003;
        in_ctrl4  = ctrl;
        in_data4  = din;
        in_valid4 = 1'b1;
        @(negedge clk);
        check_val({tag, "_ready"}, in_ready4, 1);
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        @(posedge clk); #1;
        check_val({tag, "_early"}, out_valid4, 0);
        @(posedge clk); #1;
        check_val({tag, "_valid"}, out_valid4, 1);
        check_val({tag, "_data"}, out_data4, expd);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [BW-1:0] c;
        beat_t  d, e, snap;
        beat4_t e4;
        int     p[N];
        int     acc, lat, base_idx;
        bit     got;

        in_valid32 = 1'b0; out_ready32 = 1'b1; in_data32 = '0; in_ctrl32 = '0;
        in_valid4  = 1'b0; out_ready4  = 1'b1; in_data4  = '0; in_ctrl4  = '0;
        #2 n_rst = 1'b0;
        #3;
        check_val("rst_out_valid", out_valid32, 0);
        check_val("rst_out_data", out_data32, 0);
        check_val("rst_in_ready", in_ready32, 1);
        check_val("rst_out_valid4", out_valid4, 0);
        @(posedge clk); #3 n_rst = 1'b1;
        @(posedge clk); #1;

        // Directed 4-lane cases: all-bar is identity, all-cross swaps the halves.
        e4[0] = 16'hA000; e4[1] = 16'hA001; e4[2] = 16'hA002; e4[3] = 16'hA003;
        run4("bar4", 6'b000000, e4);
        e4[0] = 16'hA002; e4[1] = 16'hA003; e4[2] = 16'hA000; e4[3] = 16'hA001;
        run4("cross4", 6'b111111, e4);

        // Fixed permutation with lane-index data.
        for (int i = 0; i < N; i++) begin
            p[i] = (13 * i + 7) % N;
            d[i] = DW'(i);
        end
        e = '0;
        for (int i = 0; i < N; i++) e[p[i]] = d[i];
        c = route_ctrl(p);
        send32(c, d, e);
        in_valid32 = 1'b0;
        drain("t3_drain", 40);

        // Back-to-back random permutations at full throughput.
        base_idx = out_cyc.size();
        stalls = 0;
        for (int b = 0; b < 64; b++) begin
            rand_beat(c, d, e);
            send32(c, d, e);
        end
        in_valid32 = 1'b0;
        drain("t4_drain", 40);
        check_val("t4_count", out_cyc.size() - base_idx, 64);
        check_val("t4_stalls", stalls, 0);
        if (out_cyc.size() >= base_idx + 64)
            check_val("t4_span", out_cyc[base_idx+63] - out_cyc[base_idx], 63);

        // Stall: the pipe fills to exactly STAGES beats and freezes its output.
        out_ready32 = 1'b0;
        acc = 0;
        snap = '0;
        rand_beat(c, d, e);
        in_ctrl32 = c; in_data32 = d; in_valid32 = 1'b1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (t == 12) snap = out_data32;
            got = in_ready32;
            if (got) begin
                exp_q.push_back(e);
                acc++;
            end
            @(posedge clk); #1;
            if (got) begin
                rand_beat(c, d, e);
                in_ctrl32 = c; in_data32 = d;
            end
        end
        in_valid32 = 1'b0;
        @(negedge clk);
        check_val("t5_accepted", acc, NC);
        check_val("t5_in_ready", in_ready32, 0);
        check_val("t5_out_valid", out_valid32, 1);
        check_val("t5_out_stable", out_data32, snap);
        @(posedge clk); #1;
        out_ready32 = 1'b1;
        drain("t5_drain", 40);

        // Reset with beats in flight: outputs clear at once, nothing stale afterwards.
        for (int b = 0; b < 3; b++) begin
            rand_beat(c, d, e);
            send32(c, d, e);
        end
        in_valid32 = 1'b0;
        @(posedge clk); #2;
        n_rst = 1'b0;
        #1;
        check_val("t6_rst_valid", out_valid32, 0);
        check_val("t6_rst_data", out_data32, 0);
        check_val("t6_rst_ready", in_ready32, 1);
        exp_q.delete();
        @(posedge clk); #3 n_rst = 1'b1;
        @(posedge clk); #1;
        rand_beat(c, d, e);
        send32(c, d, e);
        in_valid32 = 1'b0;
        lat = 0;
        for (int k = 1; k <= 3 * NC; k++) begin
            @(negedge clk);
            if (out_valid32) begin
                lat = k;
                break;
            end
        end
        check_val("t6_latency", lat, NC);
        drain("t6_drain", 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
